// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
//   Memory-side responder for the IFU/LSU path. It holds a word-addressed RAM
//   and serves one request at a time over valid/ready handshakes. Each request
//   is answered after a fixed, parameterised latency with either read data or
//   a write acknowledgement.
//
//   Phases of one request: IDLE (accept) -> WAIT (count down) -> RESP (hold
//   until taken). The RAM is updated and read at the moment RESP is entered
//   (the "commit"). A synchronous reset before the commit drops the request,
//   so a pending write never reaches the RAM.
//
// Ports
//   clk         clock
//   rst         synchronous active-high reset
//   req_valid   request present
//   req_ready   responder can accept a request (registered, high in IDLE)
//   req_wen     1 = write, 0 = read
//   req_addr    byte address
//   req_wdata   write data
//   req_wmask   byte-lane write enables
//   resp_valid  response present (registered, high in RESP)
//   resp_ready  requester accepts the response
//   resp_rdata  read data (0 for writes and errors)
//   resp_err    address misaligned or outside the RAM window
// -----------------------------------------------------------------------------
module mem_responder #(
  parameter int              XLEN       = 32,
  parameter int              DEPTH_LOG2 = 12,
  parameter logic [XLEN-1:0] BASE_ADDR  = 32'h8000_0000,
  parameter int              LATENCY    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic [XLEN/8-1:0] req_wmask,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_err
);

  localparam int              DEPTH       = 1 << DEPTH_LOG2;
  localparam int              NLANES      = XLEN / 8;
  // Size of the RAM window in bytes; offsets at or beyond this are errors.
  localparam logic [XLEN-1:0] RANGE_BYTES = XLEN'(64'(1) << (DEPTH_LOG2 + 2));

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                  state, state_next;
  logic [3:0]              counter, counter_next;
  logic                    accept;
  logic                    commit;

  // Request captured at accept time, used when the commit happens later.
  logic                    lat_wen;
  logic [XLEN-1:0]         lat_addr;
  logic [XLEN-1:0]         lat_wdata;
  logic [NLANES-1:0]       lat_wmask;

  // Operands of the commit in progress.
  logic                    c_wen;
  logic [XLEN-1:0]         c_addr;
  logic [XLEN-1:0]         c_wdata;
  logic [NLANES-1:0]       c_wmask;
  logic [XLEN-1:0]         c_offset;
  logic                    c_err;
  logic [DEPTH_LOG2-1:0]   c_idx;

  logic [XLEN-1:0]         ram [DEPTH];

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    state_next   = state;
    counter_next = counter;
    accept       = 1'b0;
    commit       = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          accept       = 1'b1;
          counter_next = 4'(LATENCY);
          if (LATENCY == 0) begin
            // Zero wait: commit straight from the request inputs.
            state_next = RESP;
            commit     = 1'b1;
          end else begin
            state_next = WAIT;
          end
        end
      end
      WAIT: begin
        counter_next = counter - 4'd1;
        if (counter == 4'd1) begin
          state_next = RESP;
          commit     = 1'b1;
        end
      end
      RESP: begin
        if (resp_valid && resp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Commit operands and address decode
  // ---------------------------------------------------------------------------
  always_comb begin
    if (state == IDLE) begin
      c_wen   = req_wen;
      c_addr  = req_addr;
      c_wdata = req_wdata;
      c_wmask = req_wmask;
    end else begin
      c_wen   = lat_wen;
      c_addr  = lat_addr;
      c_wdata = lat_wdata;
      c_wmask = lat_wmask;
    end
    // Unsigned subtraction: an address below BASE_ADDR wraps to a huge offset
    // and lands in the out-of-range error.
    c_offset = c_addr - BASE_ADDR;
    c_err    = (c_addr[1:0] != 2'b00) || (c_offset >= RANGE_BYTES);
    c_idx    = c_offset[DEPTH_LOG2+1:2];
  end

  // ---------------------------------------------------------------------------
  // Control state and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state      <= IDLE;
      counter    <= 4'd0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      state      <= state_next;
      counter    <= counter_next;
      req_ready  <= (state_next == IDLE);
      resp_valid <= (state_next == RESP);
      if (commit) begin
        resp_err   <= c_err;
        resp_rdata <= (!c_wen && !c_err) ? ram[c_idx] : '0;
      end
    end
  end

  // Captured request fields are pure data; their value only matters after an
  // accept, so they carry no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      lat_wen   <= req_wen;
      lat_addr  <= req_addr;
      lat_wdata <= req_wdata;
      lat_wmask <= req_wmask;
    end
  end

  // ---------------------------------------------------------------------------
  // RAM write port
  // ---------------------------------------------------------------------------
  // NOTE: the RAM array is deliberately not reset; contents survive rst and a
  // reset branch here would prevent mapping onto a memory macro.
  always_ff @(posedge clk) begin
    if (commit && !rst && c_wen && !c_err) begin
      for (int i = 0; i < NLANES; i++) begin
        if (c_wmask[i]) begin
          ram[c_idx][8*i +: 8] <= c_wdata[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_responder
//   Three responders with LATENCY 2, 3 and 0 share one clock and reset. A
//   word-array reference model per instance predicts read data and errors
//   from the address-window rules; directed scenarios are followed by a
//   randomized mix of reads, writes and bad addresses.
// -----------------------------------------------------------------------------
module tb_mem_responder;

  localparam int          N     = 3;
  localparam int          WORDS = 4096;
  localparam logic [31:0] BASE  = 32'h8000_0000;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [N-1:0]         req_valid;
  logic [N-1:0]         req_ready;
  logic [N-1:0]         req_wen;
  logic [N-1:0][31:0]   req_addr;
  logic [N-1:0][31:0]   req_wdata;
  logic [N-1:0][3:0]    req_wmask;
  logic [N-1:0]         resp_valid;
  logic [N-1:0]         resp_ready;
  logic [N-1:0][31:0]   resp_rdata;
  logic [N-1:0]         resp_err;

  int                   checks = 0;
  int                   errors = 0;
  int                   lat [N];
  logic [31:0]          model_mem [N][WORDS];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    mem_responder #(
      .LATENCY(g == 0 ? 2 : (g == 1 ? 3 : 0))
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_wen   (req_wen[g]),
      .req_addr  (req_addr[g]),
      .req_wdata (req_wdata[g]),
      .req_wmask (req_wmask[g]),
      .resp_valid(resp_valid[g]),
      .resp_ready(resp_ready[g]),
      .resp_rdata(resp_rdata[g]),
      .resp_err  (resp_err[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference behaviour of one transaction against instance d.
  function automatic void model_txn(input int d, input bit wen, input logic [31:0] addr,
                                    input logic [31:0] wdata, input logic [3:0] wmask,
                                    output logic [31:0] rdata, output logic err);
    logic [31:0] off;
    int          w;
    off   = addr - BASE;
    err   = (addr % 4 != 0) || (off >= 32'(4 * WORDS));
    rdata = '0;
    if (!err) begin
      w = int'(off / 4);
      if (wen) begin
        for (int b = 0; b < 4; b++)
          if (wmask[b]) model_mem[d][w][8*b +: 8] = wdata[8*b +: 8];
      end else begin
        rdata = model_mem[d][w];
      end
    end
  endfunction

  task automatic check_reset_outputs(input int d, input string tag);
    check({tag, "_req_ready"},  req_ready[d],  1);
    check({tag, "_resp_valid"}, resp_valid[d], 0);
    check({tag, "_resp_rdata"}, resp_rdata[d], 0);
    check({tag, "_resp_err"},   resp_err[d],   0);
  endtask

  // One request/response; returns at the first negedge with resp_valid high,
  // or one cycle later (after the handshake) when resp_ready is high.
  task automatic txn(input int d, input bit wen, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] wmask, input string tag);
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          n;
    model_txn(d, wen, addr, wdata, wmask, exp_rdata, exp_err);
    @(negedge clk);
    req_valid[d] = 1'b1;
    req_wen[d]   = wen;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    req_wmask[d] = wmask;
    n = 0;
    while (!req_ready[d] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready[d]) begin
      check({tag, "_accept_timeout"}, req_ready[d], 1);
      req_valid[d] = 1'b0;
      return;
    end
    @(posedge clk);
    #1 req_valid[d] = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!resp_valid[d] && n < 50);
    check({tag, "_latency"}, n, lat[d] + 1);
    check({tag, "_err"},     resp_err[d],   exp_err);
    check({tag, "_rdata"},   resp_rdata[d], exp_rdata);
    if (resp_ready[d]) begin
      @(negedge clk);
      check({tag, "_drop"},  resp_valid[d], 0);
      check({tag, "_ready"}, req_ready[d],  1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] old_word;
    logic [31:0] exp_rdata;
    logic        exp_err;
    logic [31:0] addr;
    int          r;
    lat        = '{2, 3, 0};
    req_valid  = '0;
    req_wen    = '0;
    req_addr   = '0;
    req_wdata  = '0;
    req_wmask  = '0;
    resp_ready = '1;

    // Reset values.
    repeat (2) @(negedge clk);
    for (int d = 0; d < N; d++) check_reset_outputs(d, $sformatf("reset%0d", d));
    rst = 1'b0;

    // Give the first 16 words of every instance known contents.
    for (int d = 0; d < N; d++)
      for (int w = 0; w < 16; w++)
        txn(d, 1'b1, BASE + 32'(4 * w), $urandom, 4'hF, $sformatf("init%0d_%0d", d, w));

    // Full write then read back, then a partial-lane overwrite.
    txn(0, 1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, "wr_full");
    txn(0, 1'b0, 32'h8000_0010, 32'h0,         4'h0, "rd_full");
    txn(0, 1'b1, 32'h8000_0010, 32'h1122_3344, 4'h5, "wr_lanes");
    txn(0, 1'b0, 32'h8000_0010, 32'h0,         4'h0, "rd_lanes");

    // Bad addresses: misaligned, below base, past the end; then RAM unchanged.
    txn(0, 1'b0, 32'h8000_0012, 32'h0,         4'h0, "rd_misaligned");
    txn(0, 1'b0, 32'h7FFF_FFFC, 32'h0,         4'h0, "rd_below_base");
    txn(0, 1'b1, 32'h8000_4000, 32'hCAFE_F00D, 4'hF, "wr_past_end");
    txn(0, 1'b1, 32'h8000_0011, 32'hCAFE_F00D, 4'hF, "wr_misaligned");
    txn(0, 1'b1, 32'h8000_0010, 32'hFFFF_FFFF, 4'h0, "wr_mask0");
    txn(0, 1'b0, 32'h8000_0010, 32'h0,         4'h0, "rd_unchanged");

    // Response back-pressure: outputs hold, a new request is not accepted.
    resp_ready[0] = 1'b0;
    txn(0, 1'b0, 32'h8000_0010, 32'h0, 4'h0, "stall_rd");
    req_valid[0] = 1'b1;
    req_wen[0]   = 1'b1;
    req_addr[0]  = 32'h8000_0010;
    req_wdata[0] = 32'h0BAD_0BAD;
    req_wmask[0] = 4'hF;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("stall%0d_valid", k), resp_valid[0], 1);
      check($sformatf("stall%0d_rdata", k), resp_rdata[0], model_mem[0][4]);
      check($sformatf("stall%0d_err", k),   resp_err[0],   0);
      check($sformatf("stall%0d_ready", k), req_ready[0],  0);
    end
    req_valid[0]  = 1'b0;
    resp_ready[0] = 1'b1;
    @(negedge clk);
    check("stall_release_valid", resp_valid[0], 0);
    txn(0, 1'b0, 32'h8000_0010, 32'h0, 4'h0, "stall_no_write");

    // Reset one cycle after accepting a write: write is dropped.
    old_word = model_mem[1][5];
    @(negedge clk);
    req_valid[1] = 1'b1;
    req_wen[1]   = 1'b1;
    req_addr[1]  = BASE + 32'd20;
    req_wdata[1] = ~old_word;
    req_wmask[1] = 4'hF;
    check("rst_mid_ready", req_ready[1], 1);
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs(1, "rst_mid");
    rst = 1'b0;
    txn(1, 1'b0, BASE + 32'd20, 32'h0, 4'h0, "rst_mid_old_data");

    // Zero latency, request held continuously: one accept every 2 cycles.
    exp_rdata = '0;
    @(negedge clk);
    for (int k = 0; k < 12; k++) begin
      if (k % 2 == 0) begin
        check($sformatf("b2b%0d_req_ready", k),  req_ready[2],  1);
        check($sformatf("b2b%0d_resp_valid", k), resp_valid[2], 0);
        addr = BASE + 32'(4 * $urandom_range(0, 15));
        model_txn(2, 1'b0, addr, 32'h0, 4'h0, exp_rdata, exp_err);
        req_valid[2] = 1'b1;
        req_wen[2]   = 1'b0;
        req_addr[2]  = addr;
      end else begin
        check($sformatf("b2b%0d_req_ready", k),  req_ready[2],  0);
        check($sformatf("b2b%0d_resp_valid", k), resp_valid[2], 1);
        check($sformatf("b2b%0d_rdata", k),      resp_rdata[2], exp_rdata);
        check($sformatf("b2b%0d_err", k),        resp_err[2],   0);
      end
      @(negedge clk);
    end
    req_valid[2] = 1'b0;

    // Randomized mix on every instance.
    for (int d = 0; d < N; d++) begin
      for (int i = 0; i < 50; i++) begin
        r = int'($urandom_range(0, 9));
        if (r < 7)
          addr = BASE + 32'(4 * $urandom_range(0, 15));
        else if (r == 7)
          addr = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(1, 3));
        else if (r == 8)
          addr = BASE + 32'h4000 + 32'(4 * $urandom_range(0, 100));
        else
          addr = BASE - 32'(4 * $urandom_range(1, 50));
        txn(d, 1'($urandom_range(0, 1)), addr, $urandom, 4'($urandom_range(0, 15)),
            $sformatf("rand%0d_%0d", d, i));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
